// File: rtl/axis_lane_reducer_if.sv
// AXI-Stream bundle used on both sides of the lane reducer.
// The master drives the payload and tvalid, and the slave drives tready.
interface axis_lane_reducer_if #(
    parameter int unsigned DATA_W = 64
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_lane_reducer.sv
// Per-lane sum/min/max reduction of length-headed AXI-Stream packets.
// Each packet produces one result beat per lane, and the block re-arms for the next header while enabled.
module axis_lane_reducer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned ACC_W  = 48
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       accu_en,
    input  logic [1:0]                 mode,
    output logic                       accu_busy,
    output logic                       accu_done,
    output logic                       accu_err,
    axis_lane_reducer_if.slave         s_axis,
    axis_lane_reducer_if.master        m_axis
);

    localparam int unsigned LANES  = DATA_W / LANE_W;
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned LANE_B = LANE_W / 8;
    localparam int unsigned IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0]        LAST_IDX    = IDX_W'(LANES - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_NEG_MAX = -ACC_MAX;

    typedef enum logic [1:0] {StIdle, StHdr, StData, StOut} state_e;

    state_e                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic [31:0]               len_q, len_d;
    logic [31:0]               cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q [LANES];
    logic signed [ACC_W-1:0]   acc_d [LANES];
    logic                      valid_q;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      at_len;

    function automatic logic signed [ACC_W-1:0] identity(input logic [1:0] m);
        case (m)
            2'b01:   identity = ACC_MAX;
            2'b10:   identity = ACC_NEG_MAX;
            default: identity = '0;
        endcase
    endfunction

    // Mode 11 is reserved and folds as sum.
    function automatic logic signed [ACC_W-1:0] fold(input logic [1:0]              m,
                                                     input logic signed [ACC_W-1:0] a,
                                                     input logic signed [ACC_W-1:0] x);
        case (m)
            2'b01:   fold = (x < a) ? x : a;
            2'b10:   fold = (x > a) ? x : a;
            default: fold = a + x;
        endcase
    endfunction

    assign at_len = (cnt_q == len_q - 32'd1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accu_en) state_d = StHdr;
            end
            StHdr: begin
                if (!accu_en) begin
                    state_d = StIdle;
                end else if (s_axis.tvalid) begin
                    mode_d = mode;
                    len_d  = s_axis.tdata[31:0];
                    cnt_d  = '0;
                    idx_d  = '0;
                    for (int i = 0; i < LANES; i++) acc_d[i] = identity(mode);
                    if (s_axis.tlast) err_d = 1'b1;
                    state_d = (s_axis.tdata[31:0] == 32'd0) ? StOut : StData;
                end
            end
            StData: begin
                if (!accu_en) begin
                    state_d = StIdle;
                end else if (s_axis.tvalid) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (&s_axis.tkeep[i*LANE_B +: LANE_B]) begin
                            acc_d[i] = fold(mode_q, acc_q[i],
                                            ACC_W'($signed(s_axis.tdata[i*LANE_W +: LANE_W])));
                        end
                    end
                    cnt_d = cnt_q + 32'd1;
                    // Whichever of length and tlast comes first closes the packet.
                    if (at_len || s_axis.tlast) begin
                        if (at_len != s_axis.tlast) err_d = 1'b1;
                        idx_d   = '0;
                        state_d = StOut;
                    end
                end
            end
            StOut: begin
                if (m_axis.tready && valid_q) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = accu_en ? StHdr : StIdle;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (!accu_en) err_d = 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            mode_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= (state_d == StOut);
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
        end
    end

    assign s_axis.tready = (state_q == StHdr) || (state_q == StData);
    assign accu_busy     = (state_q == StData) || (state_q == StOut);
    assign accu_done     = done_q;
    assign accu_err      = err_q;

    assign m_axis.tvalid = valid_q;
    assign m_axis.tdata  = valid_q ? DATA_W'(acc_q[idx_q]) : '0;
    assign m_axis.tkeep  = {KEEP_W{valid_q}};
    assign m_axis.tlast  = valid_q && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_axis_lane_reducer.sv
// Scoreboard bench for axis_lane_reducer: expected result beats are queued at stimulus time.
// A negedge monitor pops and compares them on each result handshake.
module tb_axis_lane_reducer;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       accu_en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       accu_busy, accu_done, accu_err;

    axis_lane_reducer_if #(.DATA_W(64)) s_if ();
    axis_lane_reducer_if #(.DATA_W(64)) m_if ();

    axis_lane_reducer #(.DATA_W(64), .LANE_W(32), .ACC_W(48)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .accu_en   (accu_en),
        .mode      (mode),
        .accu_busy (accu_busy),
        .accu_done (accu_done),
        .accu_err  (accu_err),
        .s_axis    (s_if),
        .m_axis    (m_if)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic        done_prev = 1'b0;
    logic [64:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bt(input int l1, input int l0);
        return {l1, l0};
    endfunction

    task automatic push_res(input longint l0, input longint l1);
        exp_q.push_back({1'b0, l0});
        exp_q.push_back({1'b1, l1});
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        @(negedge sys_clk);
        while (!s_if.tready && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (!s_if.tready) check("s_tready_timeout", 64'd0, 64'd1);
        @(posedge sys_clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic header(input logic [1:0] md, input int len);
        mode = md;
        drive_beat(64'(len), 8'hFF, 1'b0);
    endtask

    task automatic wait_dones(input int target);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check("done_seen", 64'(done_cnt), 64'(target));
        @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        logic [64:0] e;
        if (sys_rst_n) begin
            if (accu_done) begin
                done_cnt++;
                check("done_one_cycle", 64'(done_prev), 64'd0);
                if (accu_en) check("rearm_tready", 64'(s_if.tready), 64'd1);
            end
            done_prev = accu_done;
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", m_if.tdata, e[63:0]);
                    check("res_last", 64'(m_if.tlast), 64'(e[64]));
                    check("res_keep", 64'(m_if.tkeep), 64'hFF);
                end
            end
        end else begin
            done_prev = 1'b0;
        end
    end

    initial begin
        int n;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        #12;
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_m_tdata", m_if.tdata, 64'd0);
        check("rst_m_tkeep", 64'(m_if.tkeep), 64'd0);
        check("rst_m_tlast", 64'(m_if.tlast), 64'd0);
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_flags", {61'd0, accu_busy, accu_done, accu_err}, 64'd0);

        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        accu_en   = 1'b1;

        // Sum over three beats, with tlast landing exactly on the final beat.
        push_res(4, 9);
        header(2'b00, 3);
        drive_beat(bt(1, 2), 8'hFF, 1'b0);
        check("busy_in_data", 64'(accu_busy), 64'd1);
        drive_beat(bt(3, -4), 8'hFF, 1'b0);
        drive_beat(bt(5, 6), 8'hFF, 1'b1);
        wait_dones(1);
        check("sum_err", 64'(accu_err), 64'd0);

        // Max packet, then min packet, sent back-to-back.
        push_res(100, 3);
        header(2'b10, 2);
        drive_beat(bt(-7, 100), 8'hFF, 1'b0);
        drive_beat(bt(3, -50), 8'hFF, 1'b1);
        push_res(-50, -7);
        header(2'b01, 2);
        drive_beat(bt(-7, 100), 8'hFF, 1'b0);
        drive_beat(bt(3, -50), 8'hFF, 1'b1);
        wait_dones(3);
        check("minmax_err", 64'(accu_err), 64'd0);

        // Lane 1 is dropped from the first beat by tkeep.
        push_res(3, 2);
        header(2'b00, 2);
        drive_beat(bt(9, 1), 8'h0F, 1'b0);
        drive_beat(bt(2, 2), 8'hFF, 1'b1);
        wait_dones(4);

        // Early tlast closes the packet and raises the sticky error.
        push_res(2, 2);
        header(2'b00, 4);
        drive_beat(bt(1, 1), 8'hFF, 1'b0);
        drive_beat(bt(1, 1), 8'hFF, 1'b1);
        wait_dones(5);
        check("early_tlast_err", 64'(accu_err), 64'd1);
        @(posedge sys_clk);
        #1;
        check("err_sticky", 64'(accu_err), 64'd1);
        accu_en = 1'b0;
        @(posedge sys_clk);
        #1;
        check("err_clear", 64'(accu_err), 64'd0);
        check("idle_tready", 64'(s_if.tready), 64'd0);
        accu_en = 1'b1;

        // Reaching len without tlast is also a framing error.
        push_res(2, 2);
        header(2'b00, 2);
        drive_beat(bt(1, 1), 8'hFF, 1'b0);
        drive_beat(bt(1, 1), 8'hFF, 1'b0);
        wait_dones(6);
        check("no_tlast_err", 64'(accu_err), 64'd1);
        accu_en = 1'b0;
        @(posedge sys_clk);
        #1;
        accu_en = 1'b1;

        // Results must hold steady while the sink stalls.
        m_if.tready = 1'b0;
        push_res(7, 5);
        header(2'b00, 1);
        drive_beat(bt(5, 7), 8'hFF, 1'b1);
        n = 0;
        while (!m_if.tvalid && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            check("stall_tvalid", 64'(m_if.tvalid), 64'd1);
            check("stall_tdata", m_if.tdata, 64'd7);
            check("stall_s_tready", 64'(s_if.tready), 64'd0);
        end
        @(posedge sys_clk);
        #1;
        m_if.tready = 1'b1;
        wait_dones(7);

        // A zero-length packet returns the sum identity on every lane.
        push_res(0, 0);
        header(2'b00, 0);
        wait_dones(8);

        // Reset mid-data drops the partial packet without any output.
        header(2'b00, 3);
        drive_beat(bt(4, 4), 8'hFF, 1'b0);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_s_tready", 64'(s_if.tready), 64'd0);
        check("midrst_busy", 64'(accu_busy), 64'd0);
        check("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        push_res(-3, 10);
        header(2'b00, 1);
        drive_beat(bt(10, -3), 8'hFF, 1'b1);
        wait_dones(9);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_lane_reducer.md
# axis_lane_reducer

Parametrised, multi-lane, multi-mode AXI-Stream reduction engine for the DMA loopback path. It runs on a single clock with no internal FIFOs, and the system's FIFOs sit outside it. Each packet starts with a length header, followed by that many data beats. The block splits every data beat into signed lanes and reduces each lane independently by sum, min or max, then emits one result beat per lane. It re-arms automatically for back-to-back packets while enabled.

## Interface
- DATA_W, 64: AXIS data width in bits; must be a multiple of LANE_W and of 8.
- LANE_W, 32: signed lane width; LANES = DATA_W/LANE_W.
- ACC_W, 48: accumulator width; LANE_W <= ACC_W <= DATA_W.
- sys_clk  in  1  single clock for all logic.
- sys_rst_n  in  1  asynchronous, active-low reset.
- accu_en  in  1  level enable.
- mode  in  2  00 sum, 01 min, 10 max, 11 reserved (treated as sum); sampled at header handshake.
- accu_busy  out  1  high in HDR_WAIT is excluded; high in DATA and OUT only.
- accu_done  out  1  one-cycle pulse after the last result beat handshakes.
- accu_err  out  1  sticky framing error; cleared by reset or accu_en low.
- s_axis_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  input stream.
- m_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/DATA_W/DATA_W/8/1  result stream.

## Operation
- States: IDLE, HDR, DATA, OUT.
- Reset: state IDLE, all outputs 0, accumulators cleared, lane index 0.
- IDLE: s_axis_tready=0. Goes to HDR when accu_en=1.
- HDR: s_axis_tready=1. On handshake, latch len=tdata[31:0] and mode, and load each accumulator with the mode identity: sum 0, min +max(ACC_W), max −max(ACC_W). If len==0, go to OUT with the identity results; otherwise go to DATA with cnt=0. A header beat with tlast=1 sets accu_err.
- DATA: s_axis_tready=1. On each handshake, lane i (bits i*LANE_W +: LANE_W) is sign-extended to ACC_W and folded into acc[i] only if all its tkeep bytes are 1. Otherwise the lane is skipped. Then cnt++.
  - Sum wraps modulo 2^ACC_W.
  - Min and max use signed comparison.
  - The packet ends at the earlier of: beat cnt==len−1, or tlast=1. If the two do not coincide, accu_err is set.
  - The next state is OUT.
- OUT: s_axis_tready=0. Emits LANES beats, lane 0 first.
  - m_axis_tdata = acc[idx] sign-extended to DATA_W.
  - m_axis_tkeep is all ones.
  - m_axis_tlast=1 only on idx==LANES−1.
  - After the last handshake, accu_done pulses and the next state is HDR if accu_en=1, else IDLE.
- accu_en low in HDR or DATA: abort to IDLE next cycle, discarding partial results. accu_err clears.
- accu_en low in OUT: the current result packet completes first, as AXIS requires, then the block goes to IDLE.

## Timing
- s_axis_tready is decoded directly from the state register, giving one beat per cycle with no bubbles.
- The first result beat is valid on the cycle after the final data handshake; for len==0, the cycle after the header handshake.
- Result packet: LANES cycles minimum; back-to-back with tready=1.
- m_axis_tvalid is registered. tdata, tkeep and tlast hold stable while tvalid=1 and tready=0. tvalid never drops without a handshake, except on reset.
- After accu_done, the next header can be accepted in the following cycle.
- Minimum packet turnaround: 1 + len + LANES cycles.
- Reset mid-packet: everything returns to the reset values on the next edge, with no partial output.

## Test plan
- Sum, len=3, beats {lane1,lane0} = (1,2),(3,−4),(5,6), tlast on the third beat → results lane0=4, lane1=9; tlast on the second result; accu_done pulses 1 cycle; accu_err=0.
- Max then min back-to-back: len=2 beats (−7,100),(3,−50) with mode=10 → (100,3); next packet with mode=01, same data → (−50,−7). No idle cycle between packets is needed.
- tkeep=8'h0F on beat (9,1) of a len=2 sum with other beat (2,2) → lane0=3, lane1=2.
- Early tlast: len=4, tlast on beat 2 with data (1,1),(1,1) → results (2,2), accu_err=1 until accu_en drops. A len=2 packet without tlast also sets accu_err.
- Backpressure: m_axis_tready=0 for 5 cycles during OUT → tdata stable and s_axis_tready=0 throughout. len=0 header → two result beats of 0.
- sys_rst_n asserted mid-DATA → all outputs 0 immediately. The next packet after release gives the correct sum.
